// File: rtl/tx_fifo_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tx_fifo_arbiter
// Brief    : Round-robin burst arbiter feeding two FIFOs into one UART TX.
// Revision : 1.0 - initial release
// ============================================================================
module tx_fifo_arbiter #(
    parameter int WORD_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fifo0_empty,
    input  logic [WORD_WIDTH-1:0] fifo0_r_data,
    output logic                  fifo0_rd,
    input  logic                  fifo1_empty,
    input  logic [WORD_WIDTH-1:0] fifo1_r_data,
    output logic                  fifo1_rd,
    output logic                  tx_start,
    output logic [WORD_WIDTH-1:0] tx_data,
    input  logic                  tx_done,
    output logic [1:0]            grant,
    output logic                  busy
);

    localparam int                 c_cnt_w     = $clog2(BURST_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_burst_max = c_cnt_w'(BURST_LEN);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_grant;
    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_last;
    logic                    r_tx_start;
    logic [WORD_WIDTH-1:0]   r_tx_data;

    logic                    w_gnt_empty;
    logic [WORD_WIDTH-1:0]   w_gnt_data;
    logic [1:0]              w_pick;
    logic                    w_done;
    logic                    w_end_burst;

    assign w_gnt_empty = r_grant[0] ? fifo0_empty  : fifo1_empty;
    assign w_gnt_data  = r_grant[0] ? fifo0_r_data : fifo1_r_data;
    // tx_done coinciding with our own tx_start belongs to an earlier word.
    assign w_done      = tx_done && !r_tx_start;
    assign w_end_burst = (r_cnt == c_burst_max) || w_gnt_empty;

    always_comb begin
        w_pick = 2'b00;
        if (!fifo0_empty && !fifo1_empty) begin
            w_pick = r_last ? 2'b01 : 2'b10;
        end else if (!fifo0_empty) begin
            w_pick = 2'b01;
        end else if (!fifo1_empty) begin
            w_pick = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_grant    <= 2'b00;
            r_cnt      <= '0;
            r_last     <= 1'b1;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick != 2'b00) begin
                        r_grant <= w_pick;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!w_gnt_empty) begin
                        r_tx_data  <= w_gnt_data;
                        r_cnt      <= r_cnt + c_cnt_one;
                        r_tx_start <= 1'b1;
                        r_state    <= S_WAIT;
                    end else begin
                        r_grant <= 2'b00;
                        r_last  <= r_grant[1];
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (w_done) begin
                        if (w_end_burst) begin
                            r_grant <= 2'b00;
                            r_last  <= r_grant[1];
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Pop strobes are combinational so the pop lands in the LOAD cycle itself.
    assign fifo0_rd = (r_state == S_LOAD) && r_grant[0] && !fifo0_empty;
    assign fifo1_rd = (r_state == S_LOAD) && r_grant[1] && !fifo1_empty;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign grant    = r_grant;
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/tx_fifo_arbiter.md
TX_FIFO_ARBITER -- requirements
Module: tx_fifo_arbiter

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, width of FIFO words and UART TX data.
REQ-002 SHALL have parameter BURST_LEN, default 4, max words sent per grant (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fifo0_empty  input  1  source 0 FIFO empty flag.
REQ-006 SHALL have port fifo0_r_data  input  WORD_WIDTH  source 0 head word; valid whenever fifo0_empty=0.
REQ-007 SHALL have port fifo0_rd  output  1  one-cycle pop strobe to source 0.
REQ-008 SHALL have port fifo1_empty  input  1  source 1 FIFO empty flag.
REQ-009 SHALL have port fifo1_r_data  input  WORD_WIDTH  source 1 head word; valid whenever fifo1_empty=0.
REQ-010 SHALL have port fifo1_rd  output  1  one-cycle pop strobe to source 1.
REQ-011 SHALL have port tx_start  output  1  one-cycle request to UART TX to send tx_data.
REQ-012 SHALL have port tx_data  output  WORD_WIDTH  word to transmit; registered.
REQ-013 SHALL have port tx_done  input  1  one-cycle pulse from UART TX on end of stop bit.
REQ-014 SHALL have port grant  output  2  one-hot owner (bit0=source 0, bit1=source 1), 00 when idle.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, WAIT; grant, burst counter and last-served pointer registered.
REQ-017 IDLE: if exactly one source non-empty, SHALL grant it; if both, SHALL grant the source not equal to last-served; next state LOAD; none non-empty -> stay IDLE.
REQ-018 LOAD with granted source non-empty: SHALL assert that source's rd combinationally for exactly this cycle, capture its r_data into tx_data, increment burst counter, go WAIT.
REQ-019 LOAD with granted source empty: SHALL assert no rd, release grant, set last-served to granted source, clear burst counter, go IDLE.
REQ-020 tx_start SHALL be a registered pulse, high only the first cycle of WAIT, with tx_data already valid that cycle.
REQ-021 tx_data SHALL stay stable from tx_start until the tx_done that ends that word.
REQ-022 WAIT: tx_done SHALL be ignored in the tx_start cycle; sampled from the following cycle on; WAIT held indefinitely without tx_done.
REQ-023 WAIT on tx_done: if burst counter == BURST_LEN or granted source empty, SHALL release (grant=00, last-served=granted, counter=0, go IDLE); else go LOAD.
REQ-024 SHALL never assert fifo0_rd and fifo1_rd together, nor rd to a non-granted or empty source.
REQ-025 Latency: IDLE with source non-empty at cycle N -> rd at N+1 -> tx_start at N+2; subsequent words in a burst: tx_done at M -> rd at M+1 -> tx_start at M+2.
REQ-026 Burst counter SHALL be $clog2(BURST_LEN+1) bits and never exceed BURST_LEN.
REQ-027 Re-grant after release SHALL take at least one IDLE cycle; a source whose FIFO refills while the other is served waits for release.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, grant=00, busy=0, tx_start=0, fifo0_rd=0, fifo1_rd=0, tx_data=0, counter=0, last-served=source 1 (source 0 wins first tie).
REQ-029 Reset mid-burst SHALL abandon the word in flight; no pop or tx_start issued until normal arbitration after reset release.

Verification
REQ-030 Reset: assert reset_n=0 during WAIT -> all outputs 0 same cycle; release with both FIFOs empty -> stays IDLE, busy=0.
REQ-031 Single source: fifo0 holds 6 words A0..A5, BURST_LEN=4 -> 4 tx_start with A0..A3, release, one IDLE cycle, re-grant 01, A4,A5, release.
REQ-032 Contention: both FIFOs hold 8 words from reset -> grants 01,10,01,10 each carrying 4 words in FIFO order; exactly 16 pops total.
REQ-033 Early drain: fifo0 holds 2 words, fifo1 holds 5 -> 2 words from source 0, release, then 4 from source 1, then 1 more.
REQ-034 Timing: tx_done held high during tx_start cycle -> ignored; next word's rd only one cycle after a tx_done seen in later WAIT cycle.
REQ-035 Throughput: tx_done returned 1 cycle after tx_start -> per-word spacing of 3 cycles tx_start to tx_start within a burst; no double pops.
